stack_op_sequencer: RTL

Command sequencer that sits directly upstream of the 8-bit hardware stack and drives its push/pop/tos port. It accepts one stack-machine operation at a time over a valid/ready handshake and expands it into the required pop/compute/push cycle sequence. It then reports the produced or read value on a one-cycle result strobe. The multi-cycle datapath issues stack operations only through this block.

---
 rtl/stack_seq_pkg.sv | 48 ++++
 rtl/stack_op_sequencer_if.sv | 33 +++
 rtl/stack_seq_alu.sv | 26 ++
 rtl/stack_op_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - shared types and opcode lookups for the stack op sequencer
// Holds the data width, the 3-bit opcode enum, the sequencer state enum and
// the per-opcode lookups (binary, operand need, net push) used by the guard.
package stack_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_PUSH = 3'b000,
        OP_POP  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_NOT  = 3'b101,
        OP_TOS  = 3'b110,
        OP_DUP  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP1,
        S_POP2,
        S_RDTOS,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_e;

    // Two-operand ops: pop twice before computing.
    function automatic logic is_binary(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    // Number of stack entries the op consumes as operands.
    function automatic logic [1:0] op_needs(op_e op);
        case (op)
            OP_ADD, OP_SUB, OP_AND: return 2'd2;
            OP_PUSH:                return 2'd0;
            default:                return 2'd1;
        endcase
    endfunction

    // Ops that leave the stack one entry deeper, so they need a free slot.
    function automatic logic op_pushes(op_e op);
        return (op == OP_PUSH) || (op == OP_DUP);
    endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// rtl/stack_op_sequencer_if.sv - command, stack and result bundle of the sequencer
// master: sequencer side (drives cmd_ready, stack controls, result, busy, err).
// slave:  environment side (drives command and stk_dout).
interface stack_op_sequencer_if;
    import stack_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_imm;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_tos;
    logic [DATA_W-1:0] stk_din;
    logic [DATA_W-1:0] stk_dout;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              err;

    modport master (
        input  cmd_valid, cmd_op, cmd_imm, stk_dout,
        output cmd_ready, stk_push, stk_pop, stk_tos, stk_din,
               res_valid, res_data, busy, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_imm, stk_dout,
        input  cmd_ready, stk_push, stk_pop, stk_tos, stk_din,
               res_valid, res_data, busy, err
    );

endinterface

// File: rtl/stack_seq_alu.sv
// rtl/stack_seq_alu.sv - combinational result unit of the stack op sequencer
// Ports: op (opcode), b (deeper/only operand from stack), opa (top operand),
//        imm (push immediate), res (8-bit wrapping result).
module stack_seq_alu
    import stack_seq_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] res
);

    always_comb begin
        res = b;
        case (op)
            OP_PUSH: res = imm;
            OP_ADD:  res = b + opa;
            OP_SUB:  res = b - opa;
            OP_AND:  res = b & opa;
            OP_NOT:  res = ~b;
            default: res = b;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - expands stack-machine commands into stack port cycles
// Ports: clk, rst (asynchronous, active-high), bus (stack_op_sequencer_if.master):
//   cmd_valid/cmd_ready/cmd_op/cmd_imm  command handshake
//   stk_push/stk_pop/stk_tos/stk_din/stk_dout  stack port
//   res_valid/res_data  one-cycle result strobe, busy, err
// Parameter DEPTH: stack capacity, must match the stack.
// Optional macro STACK_GUARD_EN: occupancy guard that faults under/overflowing commands.
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter int DEPTH = 100
) (
    input  logic clk,
    input  logic rst,
    stack_op_sequencer_if.master bus
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("stack_op_sequencer: DEPTH must be at least 2");
    end

    state_e            state;
    state_e            state_n;
    op_e               op_q;
    op_e               cmd_op;
    op_e               alu_op;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] alu_imm;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] res_n;
    logic [DATA_W-1:0] res_data;
    logic              cmd_ready;
    logic              busy;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_tos;
    logic              res_valid;
    logic              accept;
    logic              fault;

    assign cmd_op = op_e'(bus.cmd_op);
    // cmd_ready is high only in IDLE, so this also implies state == S_IDLE.
    assign accept = bus.cmd_valid & cmd_ready;

    // In IDLE the ALU sees the live command (only PUSH resolves there);
    // afterwards it works on the latched command.
    assign alu_op  = (state == S_IDLE) ? cmd_op      : op_q;
    assign alu_imm = (state == S_IDLE) ? bus.cmd_imm : imm_q;

    stack_seq_alu u_alu (
        .op  (alu_op),
        .b   (bus.stk_dout),
        .opa (opa),
        .imm (alu_imm),
        .res (alu_res)
    );

`ifdef STACK_GUARD_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ;
    logic             err_q;

    assign fault = (occ < OCC_W'(op_needs(cmd_op))) ||
                   (op_pushes(cmd_op) && (occ == OCC_W'(DEPTH)));
    assign bus.err = err_q;
`else
    assign fault   = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        res_n   = res;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_n = S_DONE;
                        res_n   = '0;
                    end else begin
                        case (cmd_op)
                            OP_PUSH: begin
                                state_n = S_PUSH;
                                res_n   = alu_res;
                            end
                            OP_TOS, OP_DUP: state_n = S_RDTOS;
                            default:        state_n = S_POP1;
                        endcase
                    end
                end
            end
            S_POP1:  state_n = is_binary(op_q) ? S_POP2 : S_WAIT;
            S_POP2:  state_n = S_WAIT;
            S_RDTOS: state_n = S_WAIT;
            S_WAIT: begin
                res_n   = alu_res;
                state_n = ((op_q == OP_POP) || (op_q == OP_TOS)) ? S_DONE : S_PUSH;
            end
            S_PUSH:  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is a pure
    // function of the state it accompanies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_PUSH;
            imm_q     <= '0;
            opa       <= '0;
            res       <= '0;
            res_data  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_tos   <= 1'b0;
            res_valid <= 1'b0;
`ifdef STACK_GUARD_EN
            occ       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state <= state_n;
            res   <= res_n;
            if (accept) begin
                op_q  <= cmd_op;
                imm_q <= bus.cmd_imm;
            end
            // stk_dout here is the top element popped during POP1.
            if (state == S_POP2) begin
                opa <= bus.stk_dout;
            end
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            stk_pop   <= (state_n == S_POP1) || (state_n == S_POP2);
            stk_tos   <= (state_n == S_RDTOS);
            stk_push  <= (state_n == S_PUSH);
            res_valid <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                res_data <= res_n;
            end
`ifdef STACK_GUARD_EN
            err_q <= accept && fault;
            if (stk_push && !stk_pop) begin
                occ <= occ + 1'b1;
            end else if (stk_pop && !stk_push) begin
                occ <= occ - 1'b1;
            end
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = busy;
    assign bus.stk_push  = stk_push;
    assign bus.stk_pop   = stk_pop;
    assign bus.stk_tos   = stk_tos;
    assign bus.stk_din   = res;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;

endmodule
